// File: rtl/gpi_input_conditioner.sv
// gpi_input_conditioner: pad control, synchroniser, debounce FSM, edge pulses, sticky status and IRQ for one GPI pad
// Ports: CLK_I/RST_I clock and async active-high reset; EN_I, STE_CFG_I -> PAD_IE_O, PAD_STE_O (registered);
// PAD_DI_I[0] pad level in; DB_LIMIT_I debounce length; LEVEL_O filtered level; RISE_O/FALL_O edge pulses;
// STATUS_O sticky edge flags cleared by IRQ_CLR_I; IRQ_O masked by IRQ_MASK_I.
module gpi_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH = 8,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                EN_I,
  input  logic [1:0]          STE_CFG_I,
  input  logic [DB_WIDTH-1:0] DB_LIMIT_I,
  input  logic [1:0]          IRQ_MASK_I,
  input  logic                IRQ_CLR_I,
  input  logic [1:0]          PAD_DI_I,
  output logic                PAD_IE_O,
  output logic [1:0]          PAD_STE_O,
  output logic                LEVEL_O,
  output logic                RISE_O,
  output logic                FALL_O,
  output logic [1:0]          STATUS_O,
  output logic                IRQ_O
);
  typedef enum logic [1:0] {OFF, SETTLE, TRACK} state_t;
  localparam logic [DB_WIDTH-1:0] SETTLE_CNT = DB_WIDTH'(SYNC_STAGES + 1);
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [DB_WIDTH-1:0] cnt, cnt_inc, lim_m1;
  logic s, pad_unused;
  assign pad_unused = PAD_DI_I[1];
  assign s = sync[SYNC_STAGES-1];
  // a limit of 0 behaves like 1
  assign lim_m1 = (DB_LIMIT_I == '0) ? '0 : DB_LIMIT_I - 1'b1;
  // saturating increment
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign IRQ_O = |(STATUS_O & IRQ_MASK_I);
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= OFF;
      cnt <= '0;
      sync <= {SYNC_STAGES{RESET_LEVEL}};
      LEVEL_O <= RESET_LEVEL;
      RISE_O <= 1'b0;
      FALL_O <= 1'b0;
      STATUS_O <= 2'b00;
      PAD_IE_O <= 1'b0;
      PAD_STE_O <= 2'b00;
    end else begin
      PAD_IE_O <= EN_I;
      PAD_STE_O <= STE_CFG_I;
      sync <= {sync[SYNC_STAGES-2:0], PAD_DI_I[0]};
      RISE_O <= 1'b0;
      FALL_O <= 1'b0;
      // a new edge outranks a simultaneous clear
      STATUS_O <= (STATUS_O & ~{2{IRQ_CLR_I}}) | {FALL_O, RISE_O};
      case (state)
        OFF: begin
          cnt <= '0;
          if (EN_I) state <= SETTLE;
        end
        SETTLE: begin
          if (!EN_I) begin
            state <= OFF;
            cnt <= '0;
          end else if (cnt == SETTLE_CNT) begin
            LEVEL_O <= s;
            cnt <= '0;
            state <= TRACK;
          end else cnt <= cnt_inc;
        end
        TRACK: begin
          if (!EN_I) begin
            state <= OFF;
            cnt <= '0;
          end else if (s == LEVEL_O) cnt <= '0;
          else if (cnt == lim_m1) begin
            LEVEL_O <= s;
            cnt <= '0;
            RISE_O <= s;
            FALL_O <= !s;
          end else cnt <= cnt_inc;
        end
        default: state <= OFF;
      endcase
    end
  end
endmodule
